// File: rtl/blink_sequencer.sv
// blink_sequencer: runs a bounded burst of on/off LED blinks under a
// start/busy/done handshake. The burst parameters are latched on start.
// A phase counter times each ON and OFF phase. A remaining-count register
// tracks the blinks that have not started yet.
module blink_sequencer #(
    parameter int unsigned CW = 8,
    parameter int unsigned NW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [CW-1:0] on_len_i,
    input  logic [CW-1:0] off_len_i,
    input  logic [NW-1:0] blinks_i,
    output logic          led_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [NW-1:0] remaining_o
);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] on_len_q, on_len_d;
    logic [CW-1:0] off_len_q, off_len_d;
    logic [NW-1:0] rem_q, rem_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state logic. Outputs are decoded from the next state so they
    // can be registered alongside it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        rem_d     = rem_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    on_len_d  = on_len_i;
                    off_len_d = off_len_i;
                    if (blinks_i != '0) begin
                        state_d = StOn;
                        cnt_d   = on_len_i;
                        rem_d   = blinks_i - NW'(1);
                    end else begin
                        state_d = StDone;
                        cnt_d   = '0;
                        rem_d   = '0;
                    end
                end
            end
            StOn: begin
                if (abort_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = StOff;
                    cnt_d   = off_len_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StOff: begin
                if (abort_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (cnt_q == '0) begin
                    if (rem_q != '0) begin
                        state_d = StOn;
                        cnt_d   = on_len_q;
                        rem_d   = rem_q - NW'(1);
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                rem_d   = '0;
            end
        endcase

        led_d  = (state_d == StOn);
        busy_d = (state_d == StOn) || (state_d == StOff);
        done_d = (state_d == StDone);
    end

    // State, counters, latched parameters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
            rem_q     <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            rem_q     <= rem_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign led_o       = led_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign remaining_o = rem_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer. The stimulus side builds each
// burst's expected per-cycle output trace from the blink rules and queues
// it. A monitor pops one entry per clock and compares it with the DUT.
module tb_blink_sequencer;

    typedef struct packed {
        logic       led;
        logic       busy;
        logic       done;
        logic [3:0] rem;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] on_len;
    logic [7:0] off_len;
    logic [3:0] blinks;
    logic       led;
    logic       busy;
    logic       done;
    logic [3:0] remaining;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];    // expected outputs, one per upcoming clock edge
    exp_t plan[$];  // rest of the burst currently in progress
    exp_t cur;      // expected outputs during the present cycle

    blink_sequencer #(.CW(8), .NW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .abort_i     (abort),
        .on_len_i    (on_len),
        .off_len_i   (off_len),
        .blinks_i    (blinks),
        .led_o       (led),
        .busy_o      (busy),
        .done_o      (done),
        .remaining_o (remaining)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic l, input logic b, input logic d,
                                input logic [3:0] r);
        exp_t e;
        e.led  = l;
        e.busy = b;
        e.done = d;
        e.rem  = r;
        return e;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compare the DUT with the next scoreboard entry after each edge.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = mk(led, busy, done, remaining);
                n_checks++;
                if (act !== e) begin
                    n_errors++;
                    $display("FAIL trace at %0t: got led=%b busy=%b done=%b rem=%0d, expected led=%b busy=%b done=%b rem=%0d",
                             $time, act.led, act.busy, act.done, act.rem,
                             e.led, e.busy, e.done, e.rem);
                end
            end
        end
    end

    // Whole-burst expectation: per blink, on+1 lit cycles then off+1 dark
    // cycles, then a single done cycle.
    function automatic void build_plan(input logic [7:0] on, input logic [7:0] off,
                                       input logic [3:0] n);
        plan.delete();
        for (int b = 0; b < int'(n); b++) begin
            for (int i = 0; i <= int'(on); i++)
                plan.push_back(mk(1'b1, 1'b1, 1'b0, 4'(int'(n) - 1 - b)));
            for (int i = 0; i <= int'(off); i++)
                plan.push_back(mk(1'b0, 1'b1, 1'b0, 4'(int'(n) - 1 - b)));
        end
        plan.push_back(mk(1'b0, 1'b0, 1'b1, 4'd0));
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after it.
    task automatic cycle(input logic st, input logic ab, input logic [7:0] on,
                         input logic [7:0] off, input logic [3:0] n);
        exp_t nxt;
        @(negedge clk);
        start   = st;
        abort   = ab;
        on_len  = on;
        off_len = off;
        blinks  = n;
        if (!cur.busy && !cur.done && st) begin
            build_plan(on, off, n);
            nxt = plan.pop_front();
        end else if (cur.busy && ab) begin
            plan.delete();
            nxt = mk(1'b0, 1'b0, 1'b0, 4'd0);
        end else if (plan.size() > 0) begin
            nxt = plan.pop_front();
        end else begin
            nxt = mk(1'b0, 1'b0, 1'b0, 4'd0);
        end
        sb.push_back(nxt);
        cur = nxt;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  4'($urandom));
    endtask

    // Run the active burst until busy drops; optional abort and input noise.
    task automatic drain(input int abort_at, input bit noise);
        logic       st;
        logic [7:0] on;
        logic [7:0] off;
        logic [3:0] n;
        int         i;
        i = 1;
        while (cur.busy && i < 2000) begin
            st  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            on  = noise ? 8'($urandom) : on_len;
            off = noise ? 8'($urandom) : off_len;
            n   = noise ? 4'($urandom) : blinks;
            cycle(st, (i == abort_at), on, off, n);
            i++;
        end
        if (cur.busy) check("burst_cycle_budget", 1, 0);
    endtask

    task automatic burst(input logic [7:0] on, input logic [7:0] off, input logic [3:0] n,
                         input int abort_at, input bit noise);
        if (cur.done) cycle(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        cycle(1'b1, 1'($urandom_range(0, 1)), on, off, n);
        drain(abort_at, noise);
    endtask

    initial begin
        int ab;
        cur     = mk(1'b0, 1'b0, 1'b0, 4'd0);
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        on_len  = '0;
        off_len = '0;
        blinks  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_led", led, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_remaining", remaining, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Nominal, zero-blink and extreme phase lengths.
        burst(8'd2, 8'd1, 4'd3, -1, 1'b0);
        idle(2);
        burst(8'd5, 8'd5, 4'd0, -1, 1'b0);
        idle(1);
        burst(8'd0, 8'd0, 4'd15, -1, 1'b0);
        burst(8'd255, 8'd255, 4'd1, -1, 1'b0);
        idle(1);

        // Abort inside the second ON phase, then a restart on the next cycle.
        burst(8'd2, 8'd1, 4'd3, 7, 1'b0);
        burst(8'd2, 8'd1, 4'd3, -1, 1'b0);

        // Input noise during the burst, start in the done cycle, start after.
        burst(8'd2, 8'd1, 4'd3, -1, 1'b1);
        cycle(1'b1, 1'b0, 8'd4, 8'd4, 4'd2);
        cycle(1'b1, 1'b0, 8'd1, 8'd2, 4'd2);
        drain(-1, 1'b1);
        idle(2);

        // Asynchronous reset while the LED is lit.
        cycle(1'b1, 1'b0, 8'd3, 8'd3, 4'd5);
        repeat (2) cycle(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
        @(posedge clk);
        #3;
        check("pre_reset_led", led, int'(cur.led));
        rst = 1'b1;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_remaining", remaining, 0);
        @(negedge clk);
        rst = 1'b0;
        plan.delete();
        cur = mk(1'b0, 1'b0, 1'b0, 4'd0);
        idle(1);
        burst(8'd1, 8'd0, 4'd2, -1, 1'b0);

        // Randomised bursts.
        for (int k = 0; k < 25; k++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
            burst(8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), ab, 1'b1);
            idle(int'($urandom_range(0, 2)));
        end

        idle(3);
        @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
